// File: rtl/demod_pkg.sv
// demod_pkg: shared FSM state type and default sizing for the demodulation sequencer.
package demod_pkg;
    typedef enum logic [2:0] {IDLE, LOAD, RUN, FLUSH, DONE} demod_state_t;
    localparam int DEMOD_NTAPS = 32;
    localparam int DEMOD_COEF_W = 12;
    localparam int DEMOD_DECIM = 8;
    localparam int DEMOD_ADDR_W = $clog2(DEMOD_NTAPS);
    localparam int DEMOD_WARM_W = $clog2(DEMOD_NTAPS + 1);
    localparam int DEMOD_PHASE_W = $clog2(DEMOD_DECIM + 1);
endpackage

// File: rtl/demod_valid_pipe.sv
// demod_valid_pipe: clearable single-bit delay line of DEPTH cycles.
module demod_valid_pipe #(
    parameter int DEPTH = 1
) (
    input  logic clock,
    input  logic rst,
    input  logic clr,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge clock)
        if (rst || clr) sr <= '0;
        else sr <= DEPTH'({sr, d});
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/demod_ctrl.sv
// demod_ctrl: frame sequencer for mixer -> LPF -> downsampler; optional stall_cnt via DEMOD_CTRL_STATS_EN.
module demod_ctrl
    import demod_pkg::*;
#(
    parameter int NTAPS = DEMOD_NTAPS,
    parameter int COEF_W = DEMOD_COEF_W,
    parameter int DECIM = DEMOD_DECIM,
    parameter int FRAME_LEN = 1497600,
    parameter int MULT_LAT = 1,
    parameter int LPF_LAT = 1
) (
    input  logic                             clock,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             coef_valid,
    input  logic [COEF_W-1:0]                coef_data,
    output logic                             coef_ready,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             mult_en,
    output logic                             lpf_en,
    output logic                             lpf_coef_we,
    output logic [$clog2(NTAPS)-1:0]         lpf_coef_addr,
    output logic [COEF_W-1:0]                lpf_coef_data,
    output logic                             ds_en,
    output logic                             out_valid,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(FRAME_LEN+1)-1:0]   sample_cnt
`ifdef DEMOD_CTRL_STATS_EN
    ,
    output logic [15:0]                      stall_cnt
`endif
);
    localparam int AW = $clog2(NTAPS);
    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int WW = $clog2(NTAPS + 1);
    localparam int PW = $clog2(DECIM + 1);
    localparam int FL = MULT_LAT + LPF_LAT;
    localparam int FW = $clog2(FL + 1);

    demod_state_t state, nxt;
    logic [AW-1:0] k;
    logic [WW-1:0] w;
    logic [PW-1:0] p, p_nxt;
    logic [FW-1:0] fc;
    logic kill, coef_acc, wr, last, start_acc;

    assign kill = abort && state != IDLE;
    assign start_acc = state == IDLE && start;
    assign coef_ready = state == LOAD;
    assign in_ready = state == RUN;
    assign coef_acc = coef_valid && coef_ready;
    assign wr = coef_acc && !kill;
    assign mult_en = in_valid && in_ready;
    assign last = sample_cnt == CW'(FRAME_LEN - 1);
    assign busy = state != IDLE;
    assign done = state == DONE;
    // Phase is pinned to 0 on the first fully-warm pulse so the first decimated output lands there.
    assign p_nxt = w == WW'(NTAPS - 1) ? '0 :
                   w == WW'(NTAPS) ? (p == PW'(DECIM - 1) ? '0 : p + 1'b1) : p;
    assign ds_en = lpf_en && w >= WW'(NTAPS - 1) && p_nxt == '0;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LOAD : IDLE;
            LOAD:    nxt = coef_acc && k == AW'(NTAPS - 1) ? RUN : LOAD;
            RUN:     nxt = mult_en && last ? FLUSH : RUN;
            FLUSH:   nxt = fc == FW'(FL - 1) ? DONE : FLUSH;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
        if (kill) nxt = IDLE;
    end

    always_ff @(posedge clock)
        if (rst) state <= IDLE;
        else state <= nxt;

    always_ff @(posedge clock)
        if (rst) begin
            k <= '0;
            lpf_coef_we <= 1'b0;
            lpf_coef_addr <= '0;
            lpf_coef_data <= '0;
        end else begin
            lpf_coef_we <= wr;
            lpf_coef_addr <= wr ? k : '0;
            lpf_coef_data <= wr ? coef_data : '0;
            k <= start_acc ? '0 : (wr ? k + 1'b1 : k);
        end

    always_ff @(posedge clock)
        if (rst || start_acc) sample_cnt <= '0;
        else if (mult_en) sample_cnt <= sample_cnt + 1'b1;

    always_ff @(posedge clock)
        if (rst || kill || state == DONE) begin
            w <= '0;
            p <= '0;
        end else if (lpf_en) begin
            w <= w == WW'(NTAPS) ? w : w + 1'b1;
            p <= p_nxt;
        end

    always_ff @(posedge clock)
        if (rst || mult_en) fc <= '0;
        else if (state == FLUSH) fc <= fc + 1'b1;

    demod_valid_pipe #(.DEPTH(MULT_LAT)) u_mult_pipe (
        .clock(clock), .rst(rst), .clr(kill), .d(mult_en), .q(lpf_en)
    );

    demod_valid_pipe #(.DEPTH(LPF_LAT)) u_lpf_pipe (
        .clock(clock), .rst(rst), .clr(kill), .d(ds_en), .q(out_valid)
    );

`ifdef DEMOD_CTRL_STATS_EN
    always_ff @(posedge clock)
        if (rst || start_acc) stall_cnt <= '0;
        else if (state == RUN && !in_valid && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_demod_ctrl.sv
// tb_demod_ctrl: directed checks of demod_ctrl (64-sample and 20-sample frames, NTAPS=32, DECIM=8).
module tb_demod_ctrl;
    logic clock = 1'b0;
    logic rst = 1'b1, start = 1'b0, start_s = 1'b0, abort = 1'b0;
    logic coef_valid = 1'b0, in_valid = 1'b0;
    logic [11:0] coef_data = '0;

    logic coef_ready, in_ready, mult_en, lpf_en, lpf_coef_we, ds_en, out_valid, busy, done;
    logic [4:0] lpf_coef_addr;
    logic [11:0] lpf_coef_data;
    logic [6:0] sample_cnt;
    logic coef_ready_s, in_ready_s, mult_en_s, lpf_en_s, lpf_coef_we_s, ds_en_s, out_valid_s, busy_s, done_s;
    logic [4:0] lpf_coef_addr_s;
    logic [11:0] lpf_coef_data_s;
    logic [4:0] sample_cnt_s;
`ifdef DEMOD_CTRL_STATS_EN
    logic [15:0] stall_cnt, stall_cnt_s;
`endif

    int n_cmp = 0, n_err = 0, cyc = 0;
    int lpf_cnt, ds_cnt, ds_bad, ov_cnt, ov_bad, wr_cnt, wr_bad, done_cnt, done_cyc, last_acc;
    int lpf_s, ds_s, ov_s, done_s_cnt;
    logic ds_d = 1'b0;

    always #5 clock = ~clock;

    demod_ctrl #(.NTAPS(32), .COEF_W(12), .DECIM(8), .FRAME_LEN(64), .MULT_LAT(1), .LPF_LAT(1)) dut (
        .clock(clock), .rst(rst), .start(start), .abort(abort),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready),
        .in_valid(in_valid), .in_ready(in_ready), .mult_en(mult_en), .lpf_en(lpf_en),
        .lpf_coef_we(lpf_coef_we), .lpf_coef_addr(lpf_coef_addr), .lpf_coef_data(lpf_coef_data),
        .ds_en(ds_en), .out_valid(out_valid), .busy(busy), .done(done), .sample_cnt(sample_cnt)
`ifdef DEMOD_CTRL_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    demod_ctrl #(.NTAPS(32), .COEF_W(12), .DECIM(8), .FRAME_LEN(20), .MULT_LAT(1), .LPF_LAT(1)) dut_s (
        .clock(clock), .rst(rst), .start(start_s), .abort(abort),
        .coef_valid(coef_valid), .coef_data(coef_data), .coef_ready(coef_ready_s),
        .in_valid(in_valid), .in_ready(in_ready_s), .mult_en(mult_en_s), .lpf_en(lpf_en_s),
        .lpf_coef_we(lpf_coef_we_s), .lpf_coef_addr(lpf_coef_addr_s), .lpf_coef_data(lpf_coef_data_s),
        .ds_en(ds_en_s), .out_valid(out_valid_s), .busy(busy_s), .done(done_s), .sample_cnt(sample_cnt_s)
`ifdef DEMOD_CTRL_STATS_EN
        , .stall_cnt(stall_cnt_s)
`endif
    );

    function automatic logic [11:0] cf(int i);
        return 12'(i * 37 + 5);
    endfunction

    // Event tallies; a ds_en is legal only on LPF pulse 32, 40, 48, ... and out_valid only one cycle after ds_en.
    always @(posedge clock) begin
        cyc++;
        if (mult_en) last_acc = cyc;
        if (lpf_en) begin
            lpf_cnt++;
            if (ds_en && !(lpf_cnt >= 32 && (lpf_cnt - 32) % 8 == 0)) ds_bad++;
        end
        if (ds_en && !lpf_en) ds_bad++;
        if (ds_en) ds_cnt++;
        if (out_valid) ov_cnt++;
        if (out_valid && !ds_d) ov_bad++;
        ds_d = ds_en;
        if (lpf_coef_we) begin
            if (lpf_coef_addr != 5'(wr_cnt) || lpf_coef_data != cf(wr_cnt)) wr_bad++;
            wr_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (lpf_en_s) lpf_s++;
        if (ds_en_s) ds_s++;
        if (out_valid_s) ov_s++;
        if (done_s) done_s_cnt++;
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        lpf_cnt = 0; ds_cnt = 0; ds_bad = 0; ov_cnt = 0; ov_bad = 0; wr_cnt = 0; wr_bad = 0;
        done_cnt = 0; done_cyc = 0; last_acc = 0; lpf_s = 0; ds_s = 0; ov_s = 0; done_s_cnt = 0;
    endtask

    task automatic go(bit s);
        if (s) start_s = 1'b1;
        else start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_s = 1'b0;
    endtask

    task automatic load(bit stray);
        coef_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            coef_data = cf(i);
            start = stray && i == 5;
            @(negedge clock);
        end
        coef_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && done_cnt == 0; i++) @(negedge clock);
    endtask

    initial begin
        clr();
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 0);
        check("rst_coef_ready", coef_ready, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_we", lpf_coef_we, 0);
        check("rst_mult_en", mult_en, 0);
        check("rst_done", done, 0);
        check("rst_sample_cnt", sample_cnt, 0);
`ifdef DEMOD_CTRL_STATS_EN
        check("rst_stall", stall_cnt, 0);
`endif
        rst = 1'b0;
        @(negedge clock);

        // nominal frame with stray starts in LOAD, RUN and FLUSH
        clr();
        go(0);
        check("nom_load_ready", coef_ready, 1);
        check("nom_load_busy", busy, 1);
        load(1);
        check("nom_run_in_ready", in_ready, 1);
        check("nom_run_coef_ready", coef_ready, 0);
        in_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            start = i == 10;
            @(negedge clock);
        end
        in_valid = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("nom_flush_busy", busy, 1);
        check("nom_flush_in_ready", in_ready, 0);
        wait_done();
        check("nom_done_cnt", done_cnt, 1);
        check("nom_done_lat", done_cyc - last_acc, 3);
        check("nom_lpf_cnt", lpf_cnt, 64);
        check("nom_ds_cnt", ds_cnt, 5);
        check("nom_ds_pos", ds_bad, 0);
        check("nom_ov_cnt", ov_cnt, 5);
        check("nom_ov_timing", ov_bad, 0);
        check("nom_wr_cnt", wr_cnt, 32);
        check("nom_wr_bad", wr_bad, 0);
        check("nom_sample_cnt", sample_cnt, 64);
        check("nom_idle_busy", busy, 0);
`ifdef DEMOD_CTRL_STATS_EN
        check("nom_stall", stall_cnt, 0);
`endif

        // bubbles: in_valid alternates, 63 idle RUN cycles
        clr();
        go(0);
        load(0);
        for (int i = 0; i < 127; i++) begin
            in_valid = (i % 2) == 0;
            @(negedge clock);
        end
        in_valid = 1'b0;
        wait_done();
        check("bub_done_cnt", done_cnt, 1);
        check("bub_lpf_cnt", lpf_cnt, 64);
        check("bub_ds_cnt", ds_cnt, 5);
        check("bub_ds_pos", ds_bad, 0);
        check("bub_ov_cnt", ov_cnt, 5);
        check("bub_ov_timing", ov_bad, 0);
        check("bub_sample_cnt", sample_cnt, 64);
`ifdef DEMOD_CTRL_STATS_EN
        check("bub_stall", stall_cnt, 63);
`endif

        // abort after 40 samples
        clr();
        go(0);
        load(0);
        in_valid = 1'b1;
        repeat (40) @(negedge clock);
        in_valid = 1'b0;
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("abt_busy", busy, 0);
        check("abt_in_ready", in_ready, 0);
        check("abt_sample_cnt", sample_cnt, 40);
        repeat (5) @(negedge clock);
        check("abt_lpf_cnt", lpf_cnt, 40);
        check("abt_ds_cnt", ds_cnt, 2);
        check("abt_ov_cnt", ov_cnt, 1);
        check("abt_done_cnt", done_cnt, 0);

        // restart, then reset after 10 coefficients
        clr();
        go(0);
        check("rs_coef_ready", coef_ready, 1);
        check("rs_sample_clr", sample_cnt, 0);
        coef_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            coef_data = cf(i);
            @(negedge clock);
        end
        coef_valid = 1'b0;
        rst = 1'b1;
        @(negedge clock);
        rst = 1'b0;
        check("rl_busy", busy, 0);
        check("rl_coef_ready", coef_ready, 0);
        check("rl_we", lpf_coef_we, 0);
        check("rl_addr", lpf_coef_addr, 0);
        check("rl_sample_cnt", sample_cnt, 0);
        check("rl_wr_cnt", wr_cnt, 10);
        check("rl_wr_bad", wr_bad, 0);
        clr();
        go(0);
        load(0);
        @(negedge clock);
        check("rl2_wr_cnt", wr_cnt, 32);
        check("rl2_wr_bad", wr_bad, 0);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("rl2_abort_busy", busy, 0);

        // short frame on the FRAME_LEN=20 instance
        clr();
        go(1);
        load(0);
        in_valid = 1'b1;
        repeat (20) @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && done_s_cnt == 0; i++) @(negedge clock);
        check("sh_done_cnt", done_s_cnt, 1);
        check("sh_lpf_cnt", lpf_s, 20);
        check("sh_ds_cnt", ds_s, 0);
        check("sh_ov_cnt", ov_s, 0);
        check("sh_sample_cnt", sample_cnt_s, 20);
        check("sh_busy", busy_s, 0);
        check("sh_main_idle_lpf", lpf_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/demod_ctrl.md
# demod_ctrl

Sequencer for the demodulation chain: complex mixer, then 32-tap LPF, then downsampler. Per frame it:
- loads the LPF coefficients;
- admits input samples under a valid/ready handshake;
- generates the advance strobes for each stage, masking filter warm-up and marking decimated outputs;
- drains the pipeline and signals frame completion.

It sits between the sample/coefficient sources and the `complex_mult`/`lpf`/`downsample` datapath.

## Interface
Parameters:
- `NTAPS`, 32, LPF tap count
- `COEF_W`, 12, coefficient width (signed)
- `DECIM`, 8, downsample factor
- `FRAME_LEN`, 1497600, samples per frame
- `MULT_LAT`, 1, complex_mult register latency (cycles, ≥1)
- `LPF_LAT`, 1, lpf output latency (cycles, ≥1)

Ports:
- `clock`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin frame; honoured only in IDLE
- `abort`  in  1  cancel frame
- `coef_valid`  in  1  coefficient offered
- `coef_data`  in  COEF_W  coefficient value
- `coef_ready`  out  1  controller accepts a coefficient
- `in_valid`  in  1  input sample offered
- `in_ready`  out  1  controller accepts a sample
- `mult_en`  out  1  advance complex_mult
- `lpf_en`  out  1  shift the LPF delay line
- `lpf_coef_we`  out  1  coefficient write strobe
- `lpf_coef_addr`  out  clog2(NTAPS)  coefficient index
- `lpf_coef_data`  out  COEF_W  coefficient value
- `ds_en`  out  1  downsampler capture strobe
- `out_valid`  out  1  `sig_demod` output valid
- `busy`  out  1  state ≠ IDLE
- `done`  out  1  one-cycle frame-complete pulse
- `sample_cnt`  out  clog2(FRAME_LEN+1)  samples accepted this frame

## Operation
- FSM states: IDLE, LOAD, RUN, FLUSH, DONE.
- **IDLE**
  - Outputs are all 0.
  - `start` → LOAD; `coef_addr` and `sample_cnt` clear to 0.
- **LOAD**
  - `coef_ready` = 1.
  - Each `coef_valid & coef_ready` cycle registers `lpf_coef_we` = 1, `lpf_coef_addr` = k, `lpf_coef_data` = `coef_data`, then k++.
  - After write k = NTAPS−1 → RUN.
- **RUN**
  - `in_ready` = 1.
  - An accept (`in_valid & in_ready`) asserts combinational `mult_en` in the same cycle and increments `sample_cnt`.
  - `lpf_en` = `mult_en` delayed MULT_LAT cycles.
  - Warm counter `w` (saturates at NTAPS) counts `lpf_en` pulses.
  - Phase counter `p` is forced to 0 on the NTAPS-th pulse, then increments mod DECIM on each later pulse.
  - `ds_en` = `lpf_en` & (`w` ≥ NTAPS−1 before increment) & (`p` == 0 after update). It fires on pulses NTAPS, NTAPS+DECIM, …
  - `out_valid` = `ds_en` delayed LPF_LAT cycles.
  - Accepting the FRAME_LEN-th sample → FLUSH.
- **FLUSH**
  - `in_ready` = 0.
  - Wait until the delay lines hold no pending `lpf_en`/`out_valid`, i.e. MULT_LAT+LPF_LAT cycles after the last accept → DONE.
- **DONE**
  - `done` = 1 for one cycle → IDLE.
  - `w` and `p` clear.
- **Abort:** `abort` in any state except IDLE → IDLE next cycle.
  - Delay lines, `w` and `p` clear.
  - No `done` pulse.
  - `sample_cnt` holds its value for inspection.
- **Precedence:** `rst` > `abort` > `start`. `start` outside IDLE is ignored.
- **Stalls:** `in_valid` = 0 in RUN produces no strobes. Counters hold and phase is preserved across bubbles.

## Timing
- Reset value of every output is 0; internal state → IDLE.
- Sample accepted at cycle t:
  - `mult_en` at t;
  - `lpf_en` at t+MULT_LAT;
  - any `ds_en` at t+MULT_LAT;
  - `out_valid` at t+MULT_LAT+LPF_LAT.
- Coefficient handshake: one write per cycle at full rate; `lpf_coef_we` is registered, one cycle after the accept.
- LOAD lasts exactly NTAPS accept cycles. No sample is accepted before the last coefficient is written.
- Outputs per gap-free frame: floor((FRAME_LEN−NTAPS)/DECIM)+1 `out_valid` pulses, when FRAME_LEN ≥ NTAPS; otherwise 0.

## Configuration
- Macro `DEMOD_CTRL_STATS_EN`.
- **Defined:** adds output `stall_cnt` [15:0].
  - Counts RUN cycles with `in_valid` = 0, saturating at 16'hFFFF.
  - Cleared on `start` accept and on `rst`; holds through FLUSH/DONE/IDLE.
- **Undefined:** the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `demod_pkg` holds:
  - FSM state enum `demod_state_t`;
  - default localparams `DEMOD_NTAPS` = 32, `DEMOD_COEF_W` = 12, `DEMOD_DECIM` = 8;
  - the `clog2`-derived width constants.
- One sub-module, `demod_valid_pipe`: a parameterised-depth, clearable single-bit delay line. Instantiated twice, for MULT_LAT and LPF_LAT.

## Test plan
- **Nominal frame:** NTAPS=32, DECIM=8, FRAME_LEN=64. Load 32 coefficients back-to-back, then 64 samples gap-free → 32 `lpf_coef_we` at addr 0..31; 64 `lpf_en`; `ds_en` on pulses 32, 40, 48, 56, 64; 5 `out_valid`; `done` at cycle last accept+MULT_LAT+LPF_LAT+1; `sample_cnt` = 64.
- **Bubbles:** same frame with `in_valid` toggling every cycle → still 5 `out_valid`, each LPF_LAT after its `ds_en`. With the macro defined, `stall_cnt` equals the number of idle RUN cycles.
- **Abort mid-RUN:** `abort` after 40 samples → IDLE next cycle; no further `lpf_en`/`out_valid`; no `done`; `sample_cnt` = 40. A new `start` restarts from LOAD.
- **Stray start:** `start` asserted during LOAD, RUN and FLUSH → ignored; state and counts unchanged.
- **Short frame:** FRAME_LEN=20 < NTAPS → 20 `lpf_en`, 0 `ds_en`, 0 `out_valid`, `done` pulses once.
- **Reset mid-LOAD:** `rst` after 10 coefficients → all outputs 0 next cycle; IDLE; the next frame writes addr 0..31 again.
